// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Optional build macro: PS2_PARITY_CHECK_EN (reject frames failing odd parity).
package ps2_pkg;

  localparam int unsigned PS2_FILTER_LEN_DEF     = 8;
  localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 50000;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer, majority-free run-length glitch filter and falling-edge strobe
// for one raw PS/2 line. The filtered level idles high out of reset.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic raw_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             meta_q;
  logic             sync_q;
  logic             filt_q, filt_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
        fall_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer and filter state; bus reads as idle (high) in reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames 11-bit device-to-host words and decodes E0/F0 prefixes
// into keyCode/press/extended with a one-cycle key_valid strobe.
// Optional build macro: PS2_PARITY_CHECK_EN (frames with bad odd parity raise frame_err).
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] keyCode,
  output logic       press,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_filt_unused;
  logic clk_fall;
  logic data_filt;
  logic data_fall_unused;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .raw_i  (psClk),
    .filt_o (clk_filt_unused),
    .fall_o (clk_fall)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .raw_i  (psData),
    .filt_o (data_filt),
    .fall_o (data_fall_unused)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [7:0]      key_q, key_d;
  logic            press_q, press_d;
  logic            extd_q, extd_d;
  logic            kv_q, kv_d;
  logic            ferr_q, ferr_d;
  logic            par_ok_c;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok_c = ps2_odd_parity_ok(shift_q, par_q);
`else
  // Parity is still captured so the frame is walked bit-for-bit, but it is not enforced.
  logic par_unused;
  assign par_unused = par_q;
  assign par_ok_c   = 1'b1;
`endif

  // Frame FSM, inactivity timeout and prefix decoder.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    press_d   = press_q;
    extd_d    = extd_q;
    kv_d      = 1'b0;
    ferr_d    = 1'b0;

    if (state_q != ST_IDLE && !clk_fall) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (clk_fall && !data_filt) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          par_d   = data_filt;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          state_d = ST_IDLE;
          if (data_filt && par_ok_c) begin
            if (shift_q == PS2_EXT_PREFIX) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BREAK_PREFIX) begin
              brk_d = 1'b1;
            end else begin
              key_d   = shift_q;
              press_d = ~brk_q;
              extd_d  = ext_q;
              kv_d    = 1'b1;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An edge in the same cycle always wins over the timeout.
    if (state_q != ST_IDLE && !clk_fall && to_cnt_q == TO_LAST) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
      to_cnt_d  = '0;
      ferr_d    = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      key_q     <= 8'h00;
      press_q   <= 1'b0;
      extd_q    <= 1'b0;
      kv_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      key_q     <= key_d;
      press_q   <= press_d;
      extd_q    <= extd_d;
      kv_q      <= kv_d;
      ferr_q    <= ferr_d;
    end
  end

  assign keyCode   = key_q;
  assign press     = press_q;
  assign extended  = extd_q;
  assign key_valid = kv_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed table, hand-built corner sequences and
// randomized frames checked against a scan-code level reference model.
module tb_ps2_keyboard_rx;

  localparam int unsigned FL = 4;
  localparam int unsigned TO = 400;
  localparam int H = 20;  // half PS/2 bit period in Clk cycles
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps_clk;
  logic       ps_data;
  logic [7:0] key_code;
  logic       press;
  logic       extended;
  logic       key_valid;
  logic       frame_err;

  always #10 clk = ~clk;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .psClk    (ps_clk),
    .psData   (ps_data),
    .keyCode  (key_code),
    .press    (press),
    .extended (extended),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  int errors = 0;
  int checks = 0;

  // Strobe counters and protocol-rule monitor (overlap, pulse width, outputs move only with key_valid).
  int kv_cnt = 0;
  int ferr_cnt = 0;
  int viol = 0;
  logic [7:0] prev_key = 8'h00;
  logic prev_press = 1'b0, prev_ext = 1'b0, prev_kv = 1'b0, prev_ferr = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) kv_cnt <= kv_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if ((key_valid && frame_err) || (key_valid && prev_kv) || (frame_err && prev_ferr) ||
          (!key_valid && {key_code, press, extended} != {prev_key, prev_press, prev_ext}))
        viol <= viol + 1;
    end
    prev_key   <= key_code;
    prev_press <= press;
    prev_ext   <= extended;
    prev_kv    <= key_valid;
    prev_ferr  <= frame_err;
  end

  // Reference model: state of the prefix decoder and the held outputs.
  bit         m_ext, m_brk;
  logic [7:0] m_key;
  bit         m_press, m_extd;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_key = 8'h00; m_press = 0; m_extd = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit flip, input bit bad_stop,
                             output int ekv, output int eferr);
    ekv = 0;
    eferr = 0;
    if (bad_stop || (PCHK && flip)) eferr = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      m_key = b; m_press = !m_brk; m_extd = m_ext; m_ext = 0; m_brk = 0; ekv = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bits LSB first: start, data[7:0], parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip, input bit bad_stop);
    logic par;
    par = (~^b) ^ flip;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch,
                           input int stretch_idx, input int stretch);
    for (int i = 0; i < nbits; i++) begin
      if (i == stretch_idx) tick(stretch);
      ps_data = bits[i];
      if (glitch) begin
        tick(H / 2); ps_clk = 1'b0; tick(3); ps_clk = 1'b1; tick(H / 2 - 3);
      end else begin
        tick(H);
      end
      ps_clk = 1'b0;
      tick(H);
      ps_clk = 1'b1;
    end
    ps_data = 1'b1;
  endtask

  task automatic check_outs(input string tag, input int kv0, input int ferr0, input int ekv,
                            input int eferr, input logic [7:0] ekey, input bit epress, input bit eext);
    chk($sformatf("%s_kv", tag), 32'(kv_cnt - kv0), 32'(ekv));
    chk($sformatf("%s_ferr", tag), 32'(ferr_cnt - ferr0), 32'(eferr));
    chk($sformatf("%s_key", tag), 32'(key_code), 32'(ekey));
    chk($sformatf("%s_press", tag), 32'(press), 32'(epress));
    chk($sformatf("%s_ext", tag), 32'(extended), 32'(eext));
  endtask

  // Send one complete frame, run the model, compare.
  task automatic model_and_check(input string tag, input logic [7:0] b, input bit flip,
                                 input bit bad_stop, input bit glitch, input int stretch_idx,
                                 input int stretch);
    int kv0, ferr0, ekv, eferr;
    kv0 = kv_cnt; ferr0 = ferr_cnt;
    model_frame(b, flip, bad_stop, ekv, eferr);
    send_bits(mk_frame(b, flip, bad_stop), 11, glitch, stretch_idx, stretch);
    tick(30);
    check_outs(tag, kv0, ferr0, ekv, eferr, m_key, m_press, m_extd);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         bad_stop;
    int         e_kv;
    int         e_ferr;
    logic [7:0] e_key;
    bit         e_press;
    bit         e_ext;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int kv0, ferr0, ekv, eferr, lat;
    logic [10:0] fr;

    vecs[0] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 1, 0};
    vecs[1] = '{8'hF0, 0, 0, 0, 0, 8'h1C, 1, 0};
    vecs[2] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
    vecs[3] = '{8'hE0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[4] = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[5] = '{8'h75, 0, 0, 1, 0, 8'h75, 0, 1};
    vecs[6] = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[7] = '{8'h1C, 1, 0, 0, 1, 8'h75, 1, 0};
    vecs[8] = '{8'h5A, 0, 1, 0, 1, 8'h75, 1, 0};
`else
    vecs[7] = '{8'h1C, 1, 0, 1, 0, 8'h1C, 1, 0};
    vecs[8] = '{8'h5A, 0, 1, 0, 1, 8'h1C, 1, 0};
`endif
    vecs[9] = '{8'h12, 0, 0, 1, 0, 8'h12, 1, 0};

    ps_clk = 1'b1; ps_data = 1'b1; rst_n = 1'b0;
    model_reset();
    tick(5);
    chk("rst_key", 32'(key_code), 32'h00);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_ext", 32'(extended), 32'h0);
    chk("rst_kv", 32'(key_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    tick(10);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      kv0 = kv_cnt; ferr0 = ferr_cnt;
      model_frame(vecs[i].data, vecs[i].flip, vecs[i].bad_stop, ekv, eferr);
      send_bits(mk_frame(vecs[i].data, vecs[i].flip, vecs[i].bad_stop), 11, 0, -1, 0);
      tick(30);
      check_outs($sformatf("vec%0d", i), kv0, ferr0, vecs[i].e_kv, vecs[i].e_ferr,
                 vecs[i].e_key, vecs[i].e_press, vecs[i].e_ext);
    end

    // Stray clock pulse with data high while idle: ignored, no error.
    kv0 = kv_cnt; ferr0 = ferr_cnt;
    send_bits(11'h7FF, 1, 0, -1, 0);
    tick(30);
    chk("idle_one_kv", 32'(kv_cnt - kv0), 32'd0);
    chk("idle_one_ferr", 32'(ferr_cnt - ferr0), 32'd0);

    // E0 prefix, then a frame stalls after 4 data bits: timeout must drop the prefix too.
    model_and_check("to_pre", 8'hE0, 0, 0, 0, -1, 0);
    kv0 = kv_cnt; ferr0 = ferr_cnt;
    send_bits(mk_frame(8'h33, 0, 0), 5, 0, -1, 0);
    tick(TO + 100);
    m_ext = 0; m_brk = 0;
    check_outs("timeout", kv0, ferr0, 0, 1, m_key, m_press, m_extd);
    model_and_check("after_to", 8'h1C, 0, 0, 0, -1, 0);

    // Long but sub-timeout gap before the stop bit still completes the frame.
    model_and_check("long_gap", 8'h4D, 0, 0, 0, 10, TO - 100);

    // Latency from the stop-bit psClk fall to key_valid: 2 sync + FILTER_LEN filter + 1 decode.
    kv0 = kv_cnt; ferr0 = ferr_cnt;
    model_frame(8'h3A, 0, 0, ekv, eferr);
    fr = mk_frame(8'h3A, 0, 0);
    send_bits(fr, 10, 0, -1, 0);
    ps_data = fr[10];
    tick(H);
    ps_clk = 1'b0;
    lat = 0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      lat++;
      if (key_valid) break;
    end
    chk("lat_seen", 32'(key_valid), 32'h1);
    chk("lat_min", 32'(lat >= int'(FL) + 2), 32'h1);
    chk("lat_max", 32'(lat <= int'(FL) + 4), 32'h1);
    tick(H);
    ps_clk = 1'b1; ps_data = 1'b1;
    tick(30);
    check_outs("lat", kv0, ferr0, ekv, eferr, m_key, m_press, m_extd);

    // Reset in the middle of a frame, then a glitchy 0x29 frame.
    kv0 = kv_cnt; ferr0 = ferr_cnt;
    send_bits(mk_frame(8'h29, 0, 0), 5, 0, -1, 0);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_key", 32'(key_code), 32'h00);
    chk("midrst_kv", 32'(key_valid), 32'h0);
    chk("midrst_ferr", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    model_reset();
    tick(TO + 50);
    chk("midrst_no_kv", 32'(kv_cnt - kv0), 32'd0);
    chk("midrst_no_ferr", 32'(ferr_cnt - ferr0), 32'd0);
    model_and_check("glitch29", 8'h29, 0, 0, 1, -1, 0);

    // Randomized frames against the model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int r;
      r = int'($urandom_range(0, 7));
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else b = 8'($urandom);
      model_and_check($sformatf("rnd%0d", i), b, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 9) == 0, 0, -1, 0);
    end

    tick(5);
    chk("protocol_rules", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
